// File: rtl/data_mem_ctrl_if.sv
// Load/store request and response bundle between the MEM stage and data_mem_ctrl.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressed data memory with fixed access latency, range/alignment
// checking and LB/LH sign extension.
//
// state  | meaning
// S_IDLE | ready for a request; accepting latches it
// S_WAIT | counting down the access latency; access happens on the last WAIT edge
// S_RESP | one-cycle response pulse, then back to S_IDLE
module data_mem_ctrl #(
    parameter int    ADDR_W      = 8,
    parameter int    DEPTH       = 256,
    parameter int    BASE_OFFSET = 100,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);
    localparam int                IDX_W    = $clog2(DEPTH);
    localparam int                SUM_W    = ADDR_W + 3;
    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit                DIRECT   = (LATENCY == 1);
    localparam logic [ADDR_W-1:0] OFFSET   = ADDR_W'(BASE_OFFSET);
    localparam logic [SUM_W-1:0]  LIMIT    = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              wr_q, sgn_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] ea_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0]        mem [DEPTH];

    logic              accept, last_wait, commit;
    logic [ADDR_W-1:0] req_ea, acc_ea;
    logic              acc_wr, acc_sgn;
    logic [1:0]        acc_size;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_bytes;
    logic [SUM_W-1:0]  acc_end;
    logic              acc_err;
    logic [IDX_W-1:0]  idx [4];
    logic [7:0]        rd_byte [4];
    logic [31:0]       load_val, rdata_d;

    assign bus.req_ready  = (state_q == S_IDLE) && !rst;
    assign bus.resp_valid = (state_q == S_RESP) && !rst;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign accept    = bus.req_ready && bus.req_valid;
    assign last_wait = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
    assign req_ea    = bus.req_addr + OFFSET;

    // With single-cycle latency the access happens on the accepting edge,
    // so it has to work from the live request instead of the latched copy.
    assign commit    = !rst && (DIRECT ? accept : last_wait);
    assign acc_ea    = DIRECT ? req_ea         : ea_q;
    assign acc_wr    = DIRECT ? bus.req_write  : wr_q;
    assign acc_sgn   = DIRECT ? bus.req_signed : sgn_q;
    assign acc_size  = DIRECT ? bus.req_size   : size_q;
    assign acc_wdata = DIRECT ? bus.req_wdata  : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = DIRECT ? S_RESP : S_WAIT;
            S_WAIT:  if (last_wait) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        unique case (acc_size)
            2'b00:   acc_bytes = 3'd4;
            2'b01:   acc_bytes = 3'd2;
            default: acc_bytes = 3'd1;
        endcase
        acc_end = {3'b000, acc_ea} + SUM_W'(acc_bytes);
        acc_err = (acc_size == 2'b11)
                | ((acc_size == 2'b00) && (acc_ea[1:0] != 2'b00))
                | ((acc_size == 2'b01) && acc_ea[0])
                | (acc_end > LIMIT);
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k]     = IDX_W'(acc_ea + ADDR_W'(k));
            rd_byte[k] = mem[idx[k]];
        end
        unique case (acc_size)
            2'b00:   load_val = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
            2'b01:   load_val = {{16{acc_sgn & rd_byte[1][7]}}, rd_byte[1], rd_byte[0]};
            2'b10:   load_val = {{24{acc_sgn & rd_byte[0][7]}}, rd_byte[0]};
            default: load_val = 32'h0;
        endcase
        rdata_d = (acc_err || acc_wr) ? 32'h0 : load_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept)                 cnt_q <= CNT_INIT;
            else if (state_q == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= acc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            sgn_q   <= bus.req_signed;
            size_q  <= bus.req_size;
            wdata_q <= bus.req_wdata;
            ea_q    <= req_ea;
        end
    end

    // Contents survive reset; only the write strobe is blocked by it.
    always_ff @(posedge clk) begin
        if (commit && acc_wr && !acc_err) begin
            mem[idx[0]] <= acc_wdata[7:0];
            if (acc_size != 2'b10) mem[idx[1]] <= acc_wdata[15:8];
            if (acc_size == 2'b00) begin
                mem[idx[2]] <= acc_wdata[23:16];
                mem[idx[3]] <= acc_wdata[31:24];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: default-latency instance for functional/error/reset cases,
// single-cycle instance for back-to-back throughput.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(8)) bus0 ();
    data_mem_ctrl_if #(.ADDR_W(8)) bus1 ();

    data_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .BASE_OFFSET(100), .LATENCY(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    data_mem_ctrl #(.ADDR_W(8), .DEPTH(256), .BASE_OFFSET(100), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [7:0] addr, input logic [31:0] wd);
        bus0.req_valid  = 1'b1;
        bus0.req_write  = wr;
        bus0.req_size   = sz;
        bus0.req_signed = sg;
        bus0.req_addr   = addr;
        bus0.req_wdata  = wd;
    endtask

    task automatic idle0();
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b1;
        bus0.req_addr  = 8'hC3;
        bus0.req_wdata = 32'hBAD0BAD0;
    endtask

    // Starts and ends at a negedge in IDLE.
    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        check({tag, " ready_idle"}, 32'(bus0.req_ready), 32'd1);
        drive0(wr, sz, sg, addr, wd);
        @(posedge clk);
        @(negedge clk);
        idle0();
        check({tag, " ready_wait"}, 32'(bus0.req_ready), 32'd0);
        check({tag, " valid_wait"}, 32'(bus0.resp_valid), 32'd0);
        @(negedge clk);
        check({tag, " valid_resp"}, 32'(bus0.resp_valid), 32'd1);
        check({tag, " rdata"}, bus0.resp_rdata, exp_rd);
        check({tag, " err"}, 32'(bus0.resp_err), 32'(exp_err));
        check({tag, " ready_resp"}, 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        check({tag, " valid_after"}, 32'(bus0.resp_valid), 32'd0);
    endtask

    logic        l1_wr   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  l1_addr [4] = '{8'd0, 8'd4, 8'd0, 8'd4};
    logic [31:0] l1_wd   [4] = '{32'h11223344, 32'h55667788, 32'h0, 32'h0};
    logic [31:0] l1_exp  [4] = '{32'h0, 32'h0, 32'h11223344, 32'h55667788};

    initial begin
        idle0();
        bus0.req_size   = 2'b00;
        bus0.req_signed = 1'b0;
        bus1.req_valid  = 1'b0;
        bus1.req_write  = 1'b0;
        bus1.req_size   = 2'b00;
        bus1.req_signed = 1'b0;
        bus1.req_addr   = 8'h0;
        bus1.req_wdata  = 32'h0;

        repeat (3) @(negedge clk);
        check("rst ready", 32'(bus0.req_ready), 32'd0);
        check("rst resp_valid", 32'(bus0.resp_valid), 32'd0);
        check("rst rdata", bus0.resp_rdata, 32'h0);
        check("rst err", 32'(bus0.resp_err), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);

        txn("preload", 1'b1, 2'b00, 1'b0, 8'd0, 32'h00000011, 32'h0, 1'b0);
        txn("lw0", 1'b0, 2'b00, 1'b0, 8'd0, 32'h0, 32'h00000011, 1'b0);
        check("hold rdata", bus0.resp_rdata, 32'h00000011);

        txn("sw12", 1'b1, 2'b00, 1'b0, 8'd12, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw12", 1'b0, 2'b00, 1'b0, 8'd12, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("lb12", 1'b0, 2'b10, 1'b1, 8'd12, 32'h0, 32'hFFFFFFEF, 1'b0);
        txn("lbu12", 1'b0, 2'b10, 1'b0, 8'd12, 32'h0, 32'h000000EF, 1'b0);
        txn("lh14", 1'b0, 2'b01, 1'b1, 8'd14, 32'h0, 32'hFFFFDEAD, 1'b0);
        txn("lhu14", 1'b0, 2'b01, 1'b0, 8'd14, 32'h0, 32'h0000DEAD, 1'b0);

        txn("sb13", 1'b1, 2'b10, 1'b0, 8'd13, 32'hFFFFFF5A, 32'h0, 1'b0);
        txn("lw12_sb", 1'b0, 2'b00, 1'b0, 8'd12, 32'h0, 32'hDEAD5AEF, 1'b0);
        txn("sh14", 1'b1, 2'b01, 1'b0, 8'd14, 32'hABCD1234, 32'h0, 1'b0);
        txn("lw12_sh", 1'b0, 2'b00, 1'b0, 8'd12, 32'h0, 32'h12345AEF, 1'b0);

        txn("err_lw2", 1'b0, 2'b00, 1'b0, 8'd2, 32'h0, 32'h0, 1'b1);
        txn("err_lh1", 1'b0, 2'b01, 1'b0, 8'd1, 32'h0, 32'h0, 1'b1);
        txn("err_size3", 1'b0, 2'b11, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1);
        txn("err_lw154", 1'b0, 2'b00, 1'b0, 8'd154, 32'h0, 32'h0, 1'b1);
        txn("sw152_edge", 1'b1, 2'b00, 1'b0, 8'd152, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("lw152_edge", 1'b0, 2'b00, 1'b0, 8'd152, 32'h0, 32'hCAFEF00D, 1'b0);
        txn("lb155_edge", 1'b0, 2'b10, 1'b1, 8'd155, 32'h0, 32'hFFFFFFCA, 1'b0);
        txn("err_sw14", 1'b1, 2'b00, 1'b0, 8'd14, 32'h77777777, 32'h0, 1'b1);
        txn("lw12_nochg", 1'b0, 2'b00, 1'b0, 8'd12, 32'h0, 32'h12345AEF, 1'b0);

        // Reset on the commit edge drops the store and the response.
        txn("sw20_old", 1'b1, 2'b00, 1'b0, 8'd20, 32'hAAAABBBB, 32'h0, 1'b0);
        drive0(1'b1, 2'b00, 1'b0, 8'd20, 32'h01020304);
        @(posedge clk);
        @(negedge clk);
        idle0();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_commit resp_valid", 32'(bus0.resp_valid), 32'd0);
        check("rst_commit ready", 32'(bus0.req_ready), 32'd1);
        @(negedge clk);
        check("rst_commit resp_valid2", 32'(bus0.resp_valid), 32'd0);
        txn("lw20_old", 1'b0, 2'b00, 1'b0, 8'd20, 32'h0, 32'hAAAABBBB, 1'b0);

        // Reset during the response cycle: the store has already committed.
        drive0(1'b1, 2'b00, 1'b0, 8'd20, 32'h01020304);
        @(posedge clk);
        @(negedge clk);
        idle0();
        @(negedge clk);
        check("rst_resp valid_before", 32'(bus0.resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        txn("lw20_new", 1'b0, 2'b00, 1'b0, 8'd20, 32'h0, 32'h01020304, 1'b0);

        // Single-cycle instance with request held valid throughout.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("l1 ready_idle%0d", i), 32'(bus1.req_ready), 32'd1);
            check($sformatf("l1 valid_idle%0d", i), 32'(bus1.resp_valid), 32'd0);
            if (i == 0) begin
                bus1.req_valid = 1'b1;
                bus1.req_write = l1_wr[0];
                bus1.req_addr  = l1_addr[0];
                bus1.req_wdata = l1_wd[0];
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("l1 valid_resp%0d", i), 32'(bus1.resp_valid), 32'd1);
            check($sformatf("l1 rdata%0d", i), bus1.resp_rdata, l1_exp[i]);
            check($sformatf("l1 err%0d", i), 32'(bus1.resp_err), 32'd0);
            check($sformatf("l1 ready_resp%0d", i), 32'(bus1.req_ready), 32'd0);
            if (i < 3) begin
                bus1.req_write = l1_wr[i+1];
                bus1.req_addr  = l1_addr[i+1];
                bus1.req_wdata = l1_wd[i+1];
            end else begin
                bus1.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("l1 final idle", 32'(bus1.resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
